// File: rtl/sprite_layer_renderer.sv
// rtl/sprite_layer_renderer.sv - animated, scalable, mirrored sprite composited over a background RGB stream
module sprite_layer_renderer #(
    parameter int SPR_W      = 32,
    parameter int SPR_H      = 32,
    parameter int SCALE_SH   = 0,
    parameter int NUM_FRAMES = 4,
    parameter int FRAME_DIV  = 8,
    parameter int IDX_W      = 4,
    parameter int TRANSP_IDX = 0,
    parameter int V_ACTIVE   = 480,
    localparam int AW        = $clog2(NUM_FRAMES * SPR_W * SPR_H)
) (
    input  logic             vga_clk,
    input  logic             reset,
    input  logic [9:0]       DrawX,
    input  logic [9:0]       DrawY,
    input  logic             blank,
    input  logic [3:0]       bg_red,
    input  logic [3:0]       bg_green,
    input  logic [3:0]       bg_blue,
    input  logic [9:0]       pos_x_in,
    input  logic [9:0]       pos_y_in,
    input  logic             flip_in,
    input  logic             pos_we,
    input  logic             anim_en,
    output logic [AW-1:0]    rom_addr,
    input  logic [IDX_W-1:0] rom_q,
    output logic [IDX_W-1:0] pal_index,
    input  logic [3:0]       pal_red,
    input  logic [3:0]       pal_green,
    input  logic [3:0]       pal_blue,
    output logic [3:0]       red,
    output logic [3:0]       green,
    output logic [3:0]       blue
);

    localparam int FW     = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int DW     = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int CW     = $clog2(SPR_W);
    localparam int RW     = $clog2(SPR_H);
    localparam int FOOT_W = SPR_W << SCALE_SH;
    localparam int FOOT_H = SPR_H << SCALE_SH;

    logic [9:0]    pend_x, pend_y, act_x, act_y;
    logic          pend_flip, act_flip;
    logic [FW-1:0] frame_idx;
    logic [DW-1:0] div_cnt;
    logic          strobe;

    logic [10:0]   x11, y11, px11, py11, dx, dy;
    logic          hit;
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    logic          hit_d, blank_d;
    logic [11:0]   bg_d;

    assign strobe = (DrawX == 10'd0) && (DrawY == 10'(V_ACTIVE));

    // Placement is double-buffered so the sprite never tears mid-frame.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            pend_x    <= '0;
            pend_y    <= '0;
            pend_flip <= 1'b0;
            act_x     <= '0;
            act_y     <= '0;
            act_flip  <= 1'b0;
            frame_idx <= '0;
            div_cnt   <= '0;
        end else begin
            if (pos_we) begin
                pend_x    <= pos_x_in;
                pend_y    <= pos_y_in;
                pend_flip <= flip_in;
            end
            if (strobe) begin
                act_x    <= pos_we ? pos_x_in : pend_x;
                act_y    <= pos_we ? pos_y_in : pend_y;
                act_flip <= pos_we ? flip_in  : pend_flip;
                if (anim_en) begin
                    if (div_cnt == DW'(FRAME_DIV - 1)) begin
                        div_cnt   <= '0;
                        frame_idx <= (frame_idx == FW'(NUM_FRAMES - 1)) ? '0 : frame_idx + 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // 11-bit compare keeps a sprite hanging off the right/bottom edge from wrapping.
    always_comb begin
        x11  = {1'b0, DrawX};
        y11  = {1'b0, DrawY};
        px11 = {1'b0, act_x};
        py11 = {1'b0, act_y};
        dx   = x11 - px11;
        dy   = y11 - py11;
        hit  = (x11 >= px11) && (x11 < px11 + 11'(FOOT_W)) &&
               (y11 >= py11) && (y11 < py11 + 11'(FOOT_H));
        col  = CW'(dx >> SCALE_SH);
        row  = RW'(dy >> SCALE_SH);
        // SPR_W is a power of two, so SPR_W-1-col is the bitwise complement.
        if (act_flip) col = ~col;
        rom_addr = '0;
        if (hit)
            rom_addr = AW'(frame_idx) * AW'(SPR_W * SPR_H) + AW'(row) * AW'(SPR_W) + AW'(col);
    end

    assign pal_index = rom_q;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hit_d   <= 1'b0;
            blank_d <= 1'b0;
            bg_d    <= '0;
            red     <= '0;
            green   <= '0;
            blue    <= '0;
        end else begin
            hit_d   <= hit;
            blank_d <= blank;
            bg_d    <= {bg_red, bg_green, bg_blue};
            if (!blank_d) begin
                {red, green, blue} <= '0;
            end else if (hit_d && (pal_index != IDX_W'(TRANSP_IDX))) begin
                {red, green, blue} <= {pal_red, pal_green, pal_blue};
            end else begin
                {red, green, blue} <= bg_d;
            end
        end
    end

endmodule

// File: tb/tb_sprite_layer_renderer.sv
// tb/tb_sprite_layer_renderer.sv - scoreboard bench for sprite_layer_renderer against a reference model
module tb_sprite_layer_renderer;

    localparam int SPR_W = 32, SPR_H = 32, SCALE_SH = 1, NUM_FRAMES = 4, FRAME_DIV = 2;
    localparam int IDX_W = 4, TRANSP_IDX = 0, V_ACTIVE = 480;
    localparam int AW = $clog2(NUM_FRAMES * SPR_W * SPR_H);
    localparam int SCALE = 1 << SCALE_SH;

    logic             vga_clk = 1'b0;
    logic             reset;
    logic [9:0]       DrawX, DrawY, pos_x_in, pos_y_in;
    logic             blank, flip_in, pos_we, anim_en;
    logic [3:0]       bg_red, bg_green, bg_blue;
    logic [AW-1:0]    rom_addr;
    logic [IDX_W-1:0] rom_q, pal_index;
    logic [3:0]       pal_red, pal_green, pal_blue, red, green, blue;

    logic [IDX_W-1:0] rom [NUM_FRAMES*SPR_W*SPR_H];
    logic [11:0]      pal [1<<IDX_W];

    always #5 vga_clk = ~vga_clk;

    sprite_layer_renderer #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .SCALE_SH(SCALE_SH), .NUM_FRAMES(NUM_FRAMES),
        .FRAME_DIV(FRAME_DIV), .IDX_W(IDX_W), .TRANSP_IDX(TRANSP_IDX), .V_ACTIVE(V_ACTIVE)
    ) dut (
        .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
        .pos_x_in(pos_x_in), .pos_y_in(pos_y_in), .flip_in(flip_in), .pos_we(pos_we),
        .anim_en(anim_en), .rom_addr(rom_addr), .rom_q(rom_q), .pal_index(pal_index),
        .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
        .red(red), .green(green), .blue(blue)
    );

    // External synchronous ROM and combinational palette
    always @(posedge vga_clk) rom_q <= rom[rom_addr];
    always_comb begin
        pal_red   = pal[pal_index][11:8];
        pal_green = pal[pal_index][7:4];
        pal_blue  = pal[pal_index][3:0];
    end

    typedef struct {
        int          due;
        logic [11:0] rgb;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0, n_bad = 0;

    int   p_x, p_y, a_x, a_y, frame, divc;
    bit   p_f, a_f;
    logic [11:0] bg_val;
    bit   anim_val;

    always @(posedge vga_clk) cyc <= cyc + 1;

    always @(negedge vga_clk) begin
        if (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            if ({red, green, blue} !== e.rgb || e.due != cyc) begin
                n_bad++;
                $display("FAIL rgb cycle %0d: got %h, expected %h (due %0d)", cyc, {red, green, blue}, e.rgb, e.due);
            end
        end
    end

    task automatic step(input int x, input int y, input bit bl, input bit we,
                        input int nx, input int ny, input bit nf, input bit rst);
        bit          hit;
        int          col, row, addr;
        logic [11:0] exp_rgb;
        exp_t        e;
        @(posedge vga_clk);
        #1;
        reset    = rst;
        DrawX    = 10'(x);
        DrawY    = 10'(y);
        blank    = bl;
        {bg_red, bg_green, bg_blue} = bg_val;
        pos_we   = we;
        anim_en  = anim_val;
        if (we) begin
            pos_x_in = 10'(nx);
            pos_y_in = 10'(ny);
            flip_in  = nf;
        end

        hit  = (x >= a_x) && (x < a_x + SPR_W * SCALE) && (y >= a_y) && (y < a_y + SPR_H * SCALE);
        addr = 0;
        if (hit) begin
            col  = (x - a_x) / SCALE;
            row  = (y - a_y) / SCALE;
            if (a_f) col = SPR_W - 1 - col;
            addr = frame * SPR_W * SPR_H + row * SPR_W + col;
        end
        if (rst || !bl) exp_rgb = '0;
        else if (hit && rom[addr] != IDX_W'(TRANSP_IDX)) exp_rgb = pal[rom[addr]];
        else exp_rgb = bg_val;
        // A reset cycle also flushes the pixel issued just before it.
        if (rst && q.size() > 0 && q[q.size()-1].due > cyc) q[q.size()-1].rgb = '0;
        e.due = cyc + 2;
        e.rgb = exp_rgb;
        q.push_back(e);

        #1;
        if (!rst) begin
            n_cmp++;
            if (rom_addr !== AW'(addr)) begin
                n_bad++;
                $display("FAIL rom_addr x=%0d y=%0d: got %0d, expected %0d", x, y, rom_addr, addr);
            end
        end

        if (rst) begin
            p_x = 0; p_y = 0; p_f = 0; a_x = 0; a_y = 0; a_f = 0; frame = 0; divc = 0;
        end else begin
            if (x == 0 && y == V_ACTIVE) begin
                if (we) begin a_x = nx; a_y = ny; a_f = nf; end
                else begin a_x = p_x; a_y = p_y; a_f = p_f; end
                if (anim_val) begin
                    divc++;
                    if (divc == FRAME_DIV) begin
                        divc  = 0;
                        frame = (frame + 1) % NUM_FRAMES;
                    end
                end
            end
            if (we) begin p_x = nx; p_y = ny; p_f = nf; end
        end
    endtask

    task automatic pix(input int x, input int y);
        step(x, y, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic strobe(input bit we, input int nx, input int ny, input bit nf);
        step(0, V_ACTIVE, 1'b1, we, nx, ny, nf, 1'b0);
    endtask

    initial begin
        reset = 1'b1; DrawX = '0; DrawY = '0; blank = 1'b0;
        {bg_red, bg_green, bg_blue} = '0;
        pos_x_in = '0; pos_y_in = '0; flip_in = 1'b0; pos_we = 1'b0; anim_en = 1'b0;
        p_x = 0; p_y = 0; p_f = 0; a_x = 0; a_y = 0; a_f = 0; frame = 0; divc = 0;
        anim_val = 1'b0;
        for (int i = 0; i < NUM_FRAMES * SPR_W * SPR_H; i++) rom[i] = IDX_W'($urandom_range(0, 15));
        for (int i = 0; i < (1 << IDX_W); i++) pal[i] = 12'($urandom);
        rom[0] = 4'd5;
        rom[1] = 4'(TRANSP_IDX);
        pal[5] = 12'hABC;

        bg_val = 12'hFFF;
        repeat (3) step(0, 300, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1);
        pix(0, 300); pix(1, 300); pix(2, 300);

        step(5, 10, 1'b1, 1'b1, 100, 50, 1'b0, 1'b0);
        strobe(1'b0, 0, 0, 1'b0);
        bg_val = 12'h345;
        pix(99, 50); pix(100, 50); pix(101, 50); pix(102, 50); pix(163, 50);
        pix(164, 50); pix(100, 51); pix(130, 113); pix(130, 114);
        step(100, 50, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);

        step(3, 3, 1'b1, 1'b1, 0, 0, 1'b1, 1'b0);
        strobe(1'b0, 0, 0, 1'b0);
        pix(0, 0); pix(31, 0); pix(63, 0); pix(64, 0);

        strobe(1'b1, 100, 50, 1'b0);
        step(10, 100, 1'b1, 1'b1, 200, 200, 1'b0, 1'b0);
        pix(100, 50); pix(210, 210);
        strobe(1'b0, 0, 0, 1'b0);
        pix(100, 50); pix(210, 210);
        strobe(1'b1, 300, 300, 1'b1);
        pix(300, 300); pix(210, 210);

        strobe(1'b1, 620, 0, 1'b0);
        pix(619, 0); pix(620, 0); pix(639, 0); pix(683, 0); pix(0, 0);
        strobe(1'b1, 1000, 0, 1'b0);
        pix(1023, 10); pix(5, 10); pix(0, 0);

        strobe(1'b1, 100, 100, 1'b0);
        anim_val = 1'b1;
        for (int i = 0; i < 9; i++) begin
            strobe(1'b0, 0, 0, 1'b0);
            pix(100, 100); pix(140, 120);
        end
        anim_val = 1'b0;
        repeat (3) begin
            strobe(1'b0, 0, 0, 1'b0);
            pix(100, 100);
        end

        step(100, 100, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1);
        step(100, 100, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1);
        pix(10, 10); pix(70, 10);

        for (int i = 0; i < 3000; i++) begin
            int x, y, r;
            r = int'($urandom_range(0, 99));
            bg_val   = 12'($urandom);
            anim_val = ($urandom_range(0, 3) != 0);
            if (r < 4) begin
                strobe($urandom_range(0, 1) == 1, int'($urandom_range(0, 1023)),
                       int'($urandom_range(0, 1023)), $urandom_range(0, 1) == 1);
            end else if (r < 8) begin
                step(int'($urandom_range(1, 1023)), int'($urandom_range(0, 1023)), 1'b1, 1'b1,
                     int'($urandom_range(0, 700)), int'($urandom_range(0, 500)),
                     $urandom_range(0, 1) == 1, 1'b0);
            end else begin
                if (r < 20) begin
                    x = int'($urandom_range(0, 1023));
                    y = int'($urandom_range(0, 1023));
                end else begin
                    x = a_x + int'($urandom_range(0, 71)) - 4;
                    y = a_y + int'($urandom_range(0, 71)) - 4;
                    if (x < 0) x = 0;
                    if (x > 1023) x = 1023;
                    if (y < 0) y = 0;
                    if (y > 1023) y = 1023;
                end
                step(x, y, $urandom_range(0, 9) != 0, 1'b0, 0, 0, 1'b0, 1'b0);
            end
        end

        repeat (4) @(posedge vga_clk);
        #2;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sprite_layer_renderer.md
Name: sprite_layer_renderer

Overview:
- Parametrised successor to the full-screen ROM image drawer.
- Draws one animated, scalable, optionally mirrored sprite at a runtime-programmable position over a background RGB stream.
- Palette index 0 (configurable) is transparent.
- Sits between the VGA controller (DrawX/DrawY/blank) and the colour output; sprite ROM and palette are external instances.

Parameters:
- SPR_W, 32, sprite width in texels (power of 2)
- SPR_H, 32, sprite height in texels (power of 2)
- SCALE_SH, 0, log2 integer scale; on-screen footprint is (SPR_W<<SCALE_SH) x (SPR_H<<SCALE_SH)
- NUM_FRAMES, 4, animation frames stored back-to-back in ROM
- FRAME_DIV, 8, video frames per animation step (>=1)
- IDX_W, 4, palette index width
- TRANSP_IDX, 0, transparent palette index
- V_ACTIVE, 480, visible lines; frame strobe fires at DrawY==V_ACTIVE

Ports:
- vga_clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- blank  in  1  1 = active video
- bg_red/bg_green/bg_blue  in  4 each  background colour for the current pixel
- pos_x_in, pos_y_in  in  10 each  new sprite top-left corner
- flip_in  in  1  new horizontal-mirror setting
- pos_we  in  1  write pos_x_in/pos_y_in/flip_in to the pending registers
- anim_en  in  1  enable animation stepping
- rom_addr  out  clog2(NUM_FRAMES*SPR_W*SPR_H)  sprite ROM address (ROM is synchronous, 1-cycle read)
- rom_q  in  IDX_W  ROM data
- pal_index  out  IDX_W  equal to rom_q, driven to the external combinational palette
- pal_red/pal_green/pal_blue  in  4 each  palette colour
- red/green/blue  out  4 each  registered pixel colour

Behaviour:
- Reset values:
  - red/green/blue = 0
  - pending and active pos_x/pos_y/flip = 0
  - frame_idx = 0, div_cnt = 0
  - pipeline regs hit_d/blank_d/bg_d = 0
- Reset mid-frame: outputs are 0 on the cycle after reset is sampled; normal rendering resumes on the next pixel after reset deasserts, with the 2-cycle latency refilling.
- Double-buffered placement:
  - pos_we loads the pending regs.
  - Frame strobe (DrawX==0 && DrawY==V_ACTIVE) copies pending into active.
  - If pos_we and the strobe coincide, active takes the pos_x_in/pos_y_in/flip_in values directly (write-through).
  - Position never changes mid-frame.
- Animation:
  - On each strobe with anim_en=1: if div_cnt==FRAME_DIV-1, then div_cnt <= 0 and frame_idx <= (frame_idx==NUM_FRAMES-1) ? 0 : frame_idx+1. Otherwise div_cnt++.
  - With anim_en=0 both counters hold.
- Hit test (stage 0, combinational):
  - Uses 11-bit unsigned arithmetic, so there is no wrap.
  - hit = DrawX>=pos_x && DrawX<pos_x+(SPR_W<<SCALE_SH) && DrawY>=pos_y && DrawY<pos_y+(SPR_H<<SCALE_SH).
  - A sprite extending past screen edges is clipped.
- Address:
  - col = (DrawX-pos_x)>>SCALE_SH; if flip, col = SPR_W-1-col.
  - row = (DrawY-pos_y)>>SCALE_SH.
  - rom_addr = frame_idx*SPR_W*SPR_H + row*SPR_W + col.
  - rom_addr = 0 when !hit.
- Stage 1: the ROM returns rom_q. hit_d, blank_d and bg_d are registered copies of stage-0 hit, blank and bg_*, aligned with rom_q.
- Stage 2 (output register):
  - !blank_d -> 0.
  - Else hit_d && pal_index!=TRANSP_IDX -> palette colour.
  - Else bg_d.
- Latency: DrawX/DrawY/blank/bg presented at cycle n appear at red/green/blue at cycle n+2. Throughput is one pixel per clock.

Test Plan:
- Reset held 3 cycles with blank=1, bg=F/F/F -> rgb=0 throughout; frame_idx=0; first non-zero output 2 cycles after reset drops.
- SCALE_SH=1, pos=(100,50), flip=0, ROM texel (0,0)=5 maps to palette A/B/C -> DrawX=100..101, DrawY=50 output A/B/C; DrawX=99 and DrawX=164 output bg; latency exactly 2 cycles.
- Texel index = TRANSP_IDX inside sprite, bg=3/4/5 -> output 3/4/5; blank=0 over the sprite -> output 0.
- flip=1, SPR_W=32, SCALE_SH=0, pos=(0,0) -> DrawX=0,DrawY=0 gives rom_addr=31 (frame 0); DrawX=31 gives rom_addr=0.
- pos_we with (200,200) at mid-frame DrawY=100 -> rendering unchanged until strobe, new position from next frame; pos_we coincident with strobe -> new position used immediately.
- anim_en=1, FRAME_DIV=2, NUM_FRAMES=4 -> frame_idx 0,0,1,1,2,2,3,3,0 across 9 strobes; rom_addr base steps by 1024; anim_en=0 holds the count; pos_x=620 clips at DrawX=639 with no wrap to column 0.
